stream_burst_arbiter: RTL and testbench
=======================================

// Module: stream_burst_arbiter
// PURPOSE
// Round-robin packet arbiter sharing one valid/last/keep/data stream among NUM_SRC burst sources.
// Grant is held for a whole packet, i.e. from the first beat through the beat with last=1.
// Output is one registered slice with ready backpressure.
// Sits between the burst data masters and the single downstream packet consumer.
// PARAMETERS
// NUM_SRC    2    number of requesting sources, 2..8
// DATA_W     32   data width in bits; KEEP_W = DATA_W/8
// MAX_BEATS  258  beat limit per packet; beyond it err_long_out is set
// BEAT_W     10   width of beat counter; must satisfy 2^BEAT_W > MAX_BEATS
// PORTS
// clk            in   1                 clock; all logic on rising edge
// rst_n          in   1                 asynchronous active-low reset
// s_valid_in     in   NUM_SRC           per-source beat valid
// s_last_in      in   NUM_SRC           per-source last beat of packet
// s_keep_in      in   NUM_SRC*KEEP_W    per-source byte enables, source i at [i*KEEP_W +: KEEP_W]
// s_data_in      in   NUM_SRC*DATA_W    per-source data, source i at [i*DATA_W +: DATA_W]
// s_ready_out    out  NUM_SRC           per-source accept; beat transfers when valid & ready
// m_valid_out    out  1                 output beat valid
// m_last_out     out  1                 output last beat
// m_keep_out     out  KEEP_W            output byte enables
// m_data_out     out  DATA_W            output data
// m_src_out      out  $clog2(NUM_SRC)   index of the source that owns the current output beat
// m_ready_in     in   1                 downstream accept
// pkt_done_out   out  1                 one-cycle pulse when a last beat leaves on the m_ side
// pkt_beats_out  out  BEAT_W            beat count of the most recently completed packet
// err_long_out   out  1                 sticky; a packet exceeded MAX_BEATS; cleared only by reset
// BEHAVIOUR
// - Reset: all outputs are 0, state=IDLE, rr_ptr=0, beat counter=0.
//   Reset asserted mid-packet drops the packet: no pkt_done pulse.
// - FSM states:
//   - IDLE: if any s_valid_in is high, pick the first requester at or after rr_ptr, wrapping
//     modulo NUM_SRC. Register grant, go to XFER. No ready is asserted in IDLE.
//   - XFER: s_ready_out[g] = !m_valid_out | m_ready_in. All other ready bits are 0.
//     An accepted beat with last=1 returns to IDLE and sets rr_ptr = g+1 mod NUM_SRC.
// - Latency: request in IDLE at cycle t. Ready is high at t+1. The first beat is on m_* at t+2.
//   Inter-packet gap is at least 1 idle-arb cycle.
// - Output slice:
//   - Accepted beat loads m_* with m_valid_out=1.
//   - If m_valid_out & m_ready_in and no new beat is accepted, then m_valid_out goes to 0;
//     m_data/keep hold their last value.
//   - Holding m_valid_out with !m_ready_in: m_* are stable, s_ready_out is 0.
// - Source rules:
//   - Sources must hold their beat until ready; a source dropping valid mid-packet only inserts
//     bubbles, and the grant is kept.
//   - Non-granted sources' inputs are ignored entirely.
// - Beat counter: increments on each accepted granted beat and saturates at 2^BEAT_W-1.
//   On the last beat, pkt_beats_out = count+1, latched when that beat is accepted.
//   The counter clears to 0 at the start of the next packet.
//   Count+1 > MAX_BEATS sets err_long_out; the packet still passes unmodified.
// - pkt_done_out pulses in the cycle m_valid_out & m_ready_in & m_last_out.
// - Single-beat packet (first beat has last=1): IDLE->XFER->IDLE; pkt_beats_out = 1.
// - Simultaneous requests: rr_ptr order decides. A source re-requesting right after its own
//   packet loses to any other requester.
// - m_keep_out passes through unchanged; no zero-keep check.
// TESTING
// - Reset/idle:
//   - Assert rst_n=0 mid-packet -> all outputs 0 asynchronously.
//   - After release with no valid -> m_valid_out stays 0 for 20 cycles.
// - Single source:
//   - src0 sends 3 beats A1,A2,A3, keep 4'hF,4'hF,4'hC, m_ready_in=1.
//   - First beat on m_* 2 cycles after valid.
//   - pkt_beats_out=3, pkt_done_out pulses once, m_src_out=0.
// - Round-robin, both sources continuously valid with 2-beat packets:
//   - output packet order is 0,1,0,1;
//   - no beat interleaving within a packet.
// - Backpressure: m_ready_in toggles 1,0,0,1 during a 4-beat packet.
//   - m_* are stable while ready=0 and no beat is lost or duplicated.
//   - s_ready_out[0]=0 in stalled cycles.
// - Mid-packet bubble: src1 drops valid for 3 cycles mid-packet while src0 is valid.
//   - Grant stays on 1 and src0 receives no ready until src1's last beat.
// - Long packet with MAX_BEATS=4: a 6-beat packet passes intact.
//   - err_long_out=1 from the last beat on; pkt_beats_out=6.

Source files
------------

// File: rtl/stream_burst_arbiter.sv
// stream_burst_arbiter
// Round-robin packet arbiter: NUM_SRC valid/last/keep/data burst sources share one
// downstream stream. A grant is held from the first beat of a packet through its
// last beat. The output is a single registered slice with ready backpressure, and
// per-packet beat counting with a sticky over-length flag.
module stream_burst_arbiter #(
    parameter int NUM_SRC   = 2,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 258,
    parameter int BEAT_W    = 10,
    localparam int KEEP_W   = DATA_W / 8,
    localparam int SRC_W    = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        s_valid_in,
    input  logic [NUM_SRC-1:0]        s_last_in,
    input  logic [NUM_SRC*KEEP_W-1:0] s_keep_in,
    input  logic [NUM_SRC*DATA_W-1:0] s_data_in,
    output logic [NUM_SRC-1:0]        s_ready_out,
    output logic                      m_valid_out,
    output logic                      m_last_out,
    output logic [KEEP_W-1:0]         m_keep_out,
    output logic [DATA_W-1:0]         m_data_out,
    output logic [SRC_W-1:0]          m_src_out,
    input  logic                      m_ready_in,
    output logic                      pkt_done_out,
    output logic [BEAT_W-1:0]         pkt_beats_out,
    output logic                      err_long_out
);

    localparam logic [SRC_W:0]  NUM_SRC_W = (SRC_W + 1)'(NUM_SRC);
    localparam logic [BEAT_W:0] MAX_W     = (BEAT_W + 1)'(MAX_BEATS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SRC_W-1:0]    grant_q, grant_d;
    logic [SRC_W-1:0]    rr_q, rr_d;
    logic [BEAT_W-1:0]   cnt_q, cnt_d;
    logic [BEAT_W-1:0]   beats_q, beats_d;
    logic                err_q, err_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;
    logic [KEEP_W-1:0]   m_keep_q, m_keep_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [SRC_W-1:0]    m_src_q, m_src_d;

    // Per-source views of the flattened data/keep buses
    logic [DATA_W-1:0] data_arr [NUM_SRC];
    logic [KEEP_W-1:0] keep_arr [NUM_SRC];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign data_arr[gi] = s_data_in[gi*DATA_W +: DATA_W];
            assign keep_arr[gi] = s_keep_in[gi*KEEP_W +: KEEP_W];
        end
    endgenerate

    // Round-robin search: rotate requests so bit 0 is the source at rr_ptr
    logic [NUM_SRC-1:0] req_rot;
    logic               pick_found;
    logic [SRC_W:0]     pick_sum;
    logic [SRC_W-1:0]   pick;

    assign req_rot = NUM_SRC'({s_valid_in, s_valid_in} >> rr_q);

    // First requester at or after rr_ptr, wrapping modulo NUM_SRC
    always_comb begin
        pick_found = 1'b0;
        pick_sum   = '0;
        pick       = rr_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!pick_found && req_rot[k]) begin
                pick_found = 1'b1;
                pick_sum   = {1'b0, rr_q} + (SRC_W + 1)'(k);
                if (pick_sum >= NUM_SRC_W) begin
                    pick_sum = pick_sum - NUM_SRC_W;
                end
                pick = pick_sum[SRC_W-1:0];
            end
        end
    end

    // Only the granted source may see ready, and only when the slice can take a beat
    logic             ready_g;
    logic             accept;
    logic [SRC_W:0]   grant_p1;
    logic [SRC_W-1:0] rr_after;
    logic [BEAT_W:0]  cnt_p1;
    logic [BEAT_W-1:0] cnt_inc;

    assign ready_g     = (state_q == ST_XFER) && (!m_valid_q || m_ready_in);
    assign s_ready_out = ready_g ? (NUM_SRC'(1) << grant_q) : '0;
    assign accept      = ready_g && s_valid_in[grant_q];

    assign grant_p1 = {1'b0, grant_q} + (SRC_W + 1)'(1);
    assign rr_after = (grant_p1 == NUM_SRC_W) ? '0 : grant_p1[SRC_W-1:0];

    // Saturating count+1: the MSB of the widened sum flags overflow
    assign cnt_p1  = {1'b0, cnt_q} + (BEAT_W + 1)'(1);
    assign cnt_inc = cnt_p1[BEAT_W] ? cnt_q : cnt_p1[BEAT_W-1:0];

    // Next-state: arbitration FSM, beat counting and the output slice
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        beats_d   = beats_q;
        err_d     = err_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_keep_d  = m_keep_q;
        m_data_d  = m_data_q;
        m_src_d   = m_src_q;

        case (state_q)
            ST_IDLE: begin
                if (|s_valid_in) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (s_last_in[grant_q]) begin
                        beats_d = cnt_inc;
                        if (cnt_p1 > MAX_W) begin
                            err_d = 1'b1;
                        end
                        rr_d    = rr_after;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new beat overwrites the slice; otherwise a taken beat just clears valid
        if (accept) begin
            m_valid_d = 1'b1;
            m_last_d  = s_last_in[grant_q];
            m_keep_d  = keep_arr[grant_q];
            m_data_d  = data_arr[grant_q];
            m_src_d   = grant_q;
        end else if (m_valid_q && m_ready_in) begin
            m_valid_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            beats_q   <= '0;
            err_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_keep_q  <= '0;
            m_data_q  <= '0;
            m_src_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            beats_q   <= beats_d;
            err_q     <= err_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_keep_q  <= m_keep_d;
            m_data_q  <= m_data_d;
            m_src_q   <= m_src_d;
        end
    end

    assign m_valid_out   = m_valid_q;
    assign m_last_out    = m_last_q;
    assign m_keep_out    = m_keep_q;
    assign m_data_out    = m_data_q;
    assign m_src_out     = m_src_q;
    assign pkt_beats_out = beats_q;
    assign err_long_out  = err_q;
    assign pkt_done_out  = m_valid_q && m_ready_in && m_last_q;

endmodule

// File: tb/tb_stream_burst_arbiter.sv
// Testbench for stream_burst_arbiter: per-source packet drivers, a scoreboard of
// expected beats per source, and a monitor that checks every output handshake.
module tb_stream_burst_arbiter;

    localparam int NSRC = 2;
    localparam int DW   = 32;
    localparam int KW   = DW / 8;
    localparam int MAXB = 4;
    localparam int BW   = 10;

    logic              clk;
    logic              rst_n;
    logic [NSRC-1:0]   s_valid_in;
    logic [NSRC-1:0]   s_last_in;
    logic [NSRC*KW-1:0] s_keep_in;
    logic [NSRC*DW-1:0] s_data_in;
    logic [NSRC-1:0]   s_ready_out;
    logic              m_valid_out;
    logic              m_last_out;
    logic [KW-1:0]     m_keep_out;
    logic [DW-1:0]     m_data_out;
    logic              m_src_out;
    logic              m_ready_in;
    logic              pkt_done_out;
    logic [BW-1:0]     pkt_beats_out;
    logic              err_long_out;

    stream_burst_arbiter #(
        .NUM_SRC  (NSRC),
        .DATA_W   (DW),
        .MAX_BEATS(MAXB),
        .BEAT_W   (BW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid_in   (s_valid_in),
        .s_last_in    (s_last_in),
        .s_keep_in    (s_keep_in),
        .s_data_in    (s_data_in),
        .s_ready_out  (s_ready_out),
        .m_valid_out  (m_valid_out),
        .m_last_out   (m_last_out),
        .m_keep_out   (m_keep_out),
        .m_data_out   (m_data_out),
        .m_src_out    (m_src_out),
        .m_ready_in   (m_ready_in),
        .pkt_done_out (pkt_done_out),
        .pkt_beats_out(pkt_beats_out),
        .err_long_out (err_long_out)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        int            gap;
    } beat_t;

    beat_t stim_q [NSRC][$];
    beat_t exp_q  [NSRC][$];
    int    len_q  [NSRC][$];
    int    order_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pkt_id = 0;
    int pkts_sent = 0;
    int done_cnt = 0;
    int bub_pct = 0;
    int rdy_mode = 0;      // 0: always ready, 1: random, 2: driven by the test sequence
    logic [NSRC-1:0] cur_v = '0;
    logic [NSRC-1:0] fire = '0;

    // monitor state
    logic          in_pkt = 1'b0;
    logic          owner = 1'b0;
    logic          err_exp = 1'b0;
    logic          stall_prev = 1'b0;
    logic [DW+KW+2-1:0] snap;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue one packet on a source; the scoreboard gets the same beats and length
    task automatic send_pkt(input int src, input int n, input logic [KW-1:0] k_mid,
                            input logic [KW-1:0] k_last, input int gap_at, input int gap_len);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = {4'(src), 12'(pkt_id), 16'(i)};
            b.keep = (i == n - 1) ? k_last : k_mid;
            b.last = (i == n - 1);
            b.gap  = (i == gap_at) ? gap_len : 0;
            stim_q[src].push_back(b);
            exp_q[src].push_back(b);
        end
        len_q[src].push_back(n);
        pkt_id++;
        pkts_sent++;
        $display("queued packet src=%0d beats=%0d", src, n);
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while ((stim_q[0].size() + stim_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0
               && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats left after %0d cycles",
                     stim_q[0].size() + stim_q[1].size() + exp_q[0].size() + exp_q[1].size(), budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_m_valid(input int budget);
        int c;
        c = 0;
        @(negedge clk);
        while (!m_valid_out && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (!m_valid_out) begin
            checks++;
            errors++;
            $display("FAIL wait_m_valid: got m_valid_out=0 expected 1 within %0d cycles", budget);
        end
    endtask

    // Source drivers and downstream ready: handshakes sampled mid-cycle, inputs updated after the edge
    always begin
        beat_t b;
        @(negedge clk);
        for (int i = 0; i < NSRC; i++) fire[i] = rst_n && s_valid_in[i] && s_ready_out[i];
        @(posedge clk);
        #1;
        for (int i = 0; i < NSRC; i++) begin
            if (fire[i]) begin
                if (stim_q[i].size() > 0) void'(stim_q[i].pop_front());
                cur_v[i] = 1'b0;
            end
            if (!cur_v[i] && stim_q[i].size() > 0) begin
                if (stim_q[i][0].gap > 0) begin
                    b = stim_q[i].pop_front();
                    b.gap = b.gap - 1;
                    stim_q[i].push_front(b);
                end else if ($urandom_range(99) >= bub_pct) begin
                    cur_v[i] = 1'b1;
                end
            end
            s_valid_in[i] = cur_v[i];
            if (cur_v[i]) begin
                b = stim_q[i][0];
                s_data_in[i*DW +: DW] = b.data;
                s_keep_in[i*KW +: KW] = b.keep;
                s_last_in[i]          = b.last;
            end else begin
                s_last_in[i] = 1'b0;
            end
        end
        if (rdy_mode == 0) m_ready_in = 1'b1;
        else if (rdy_mode == 1) m_ready_in = ($urandom_range(99) < 70);
    end

    // Monitor: checks each output handshake against the scoreboard and slice stability
    always @(negedge clk) begin
        beat_t e;
        int    s;
        int    n;
        if (!rst_n) begin
            in_pkt     = 1'b0;
            stall_prev = 1'b0;
            err_exp    = 1'b0;
        end else begin
            s = int'(m_src_out);
            if (m_valid_out && m_last_out && len_q[s].size() > 0 && len_q[s][0] > MAXB)
                err_exp = 1'b1;
            chk("err_long", err_long_out, err_exp);
            chk("ready_onehot0", ($countones(s_ready_out) <= 1), 1);

            if (stall_prev) begin
                chk("stall_stable", {m_valid_out, m_last_out, m_keep_out, m_data_out, m_src_out},
                    {1'b1, snap});
            end
            stall_prev = m_valid_out && !m_ready_in;
            snap = {m_last_out, m_keep_out, m_data_out, m_src_out};
            if (stall_prev) chk("stall_s_ready", s_ready_out, 0);

            if (m_valid_out && m_ready_in) begin
                if (exp_q[s].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got src=%0d data=0x%0h expected no beat", s, m_data_out);
                end else begin
                    e = exp_q[s].pop_front();
                    chk("beat_data_keep_last", {m_data_out, m_keep_out, m_last_out},
                        {e.data, e.keep, e.last});
                    if (!in_pkt) begin
                        if (order_q.size() > 0) chk("pkt_order", m_src_out, order_q.pop_front());
                        owner = m_src_out;
                    end else begin
                        chk("no_interleave", m_src_out, owner);
                    end
                    in_pkt = !e.last;
                    chk("pkt_done_on_beat", pkt_done_out, e.last);
                    $display("beat src=%0d data=0x%08h keep=0x%0h last=%0d", s, m_data_out, m_keep_out, m_last_out);
                    if (e.last) begin
                        n = len_q[s].pop_front();
                        chk("pkt_beats", pkt_beats_out, n);
                        if (pkt_done_out) done_cnt++;
                    end
                end
            end else begin
                chk("pkt_done_idle", pkt_done_out, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int tv, tm, c, rdy0_cnt, dc0;
        rst_n      = 1'b0;
        s_valid_in = '0;
        s_last_in  = '0;
        s_keep_in  = '0;
        s_data_in  = '0;
        m_ready_in = 1'b1;

        // Reset state and quiet idle
        repeat (3) @(posedge clk);
        #1;
        chk("reset_m_valid", m_valid_out, 0);
        chk("reset_s_ready", s_ready_out, 0);
        chk("reset_beats_err", {pkt_beats_out, err_long_out}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_no_valid", m_valid_out, 0);
        end

        // Single source, 3 beats, latency check
        send_pkt(0, 3, 4'hF, 4'hC, -1, 0);
        order_q.push_back(0);
        tv = -1;
        tm = -1;
        for (int i = 0; i < 50 && tm < 0; i++) begin
            @(negedge clk);
            if (tv < 0 && s_valid_in[0]) tv = cyc;
            if (tm < 0 && m_valid_out) tm = cyc;
        end
        chk("first_beat_latency", tm - tv, 2);
        wait_drain(200);
        chk("single_done_count", done_cnt, 1);
        chk("single_beats", pkt_beats_out, 3);

        // One packet from src1 so the round-robin pointer returns to 0
        send_pkt(1, 2, 4'hF, 4'h3, -1, 0);
        order_q.push_back(1);
        wait_drain(200);

        // Both sources continuously valid with 2-beat packets
        send_pkt(0, 2, 4'hF, 4'hF, -1, 0);
        send_pkt(0, 2, 4'hF, 4'h7, -1, 0);
        send_pkt(1, 2, 4'hF, 4'h1, -1, 0);
        send_pkt(1, 2, 4'hF, 4'hE, -1, 0);
        order_q.push_back(0);
        order_q.push_back(1);
        order_q.push_back(0);
        order_q.push_back(1);
        wait_drain(400);
        chk("rr_order_consumed", order_q.size(), 0);

        // Backpressure: ready 1,0,0,1 during a 4-beat packet
        rdy_mode = 2;
        m_ready_in = 1'b1;
        send_pkt(0, 4, 4'hF, 4'h8, -1, 0);
        order_q.push_back(0);
        wait_m_valid(50);
        @(posedge clk); #1; m_ready_in = 1'b0;
        @(negedge clk); chk("bp_s_ready0_stall", s_ready_out[0], 0);
        @(posedge clk); #1; m_ready_in = 1'b0;
        @(negedge clk); chk("bp_s_ready0_stall", s_ready_out[0], 0);
        @(posedge clk); #1; m_ready_in = 1'b1;
        rdy_mode = 0;
        wait_drain(200);
        chk("bp_beats", pkt_beats_out, 4);

        // Mid-packet bubble on src1 while src0 waits
        send_pkt(1, 4, 4'hF, 4'hF, 2, 3);
        send_pkt(0, 2, 4'hF, 4'h5, -1, 0);
        order_q.push_back(1);
        order_q.push_back(0);
        rdy0_cnt = 0;
        c = 0;
        while (c < 100) begin
            @(negedge clk);
            if (s_ready_out[0]) rdy0_cnt++;
            c++;
            if (s_valid_in[1] && s_ready_out[1] && s_last_in[1]) break;
        end
        chk("bubble_src0_no_ready", rdy0_cnt, 0);
        chk("bubble_src1_finished", (c < 100), 1);
        wait_drain(200);

        // Randomized traffic with bubbles and random downstream ready
        rdy_mode = 1;
        bub_pct = 30;
        for (int i = 0; i < 40; i++) begin
            send_pkt($urandom_range(NSRC - 1), $urandom_range(MAXB, 1), 4'($urandom),
                     4'($urandom), -1, 0);
            repeat ($urandom_range(3)) @(negedge clk);
        end
        wait_drain(5000);
        chk("random_done_count", done_cnt, pkts_sent);
        rdy_mode = 0;
        bub_pct = 0;

        // Over-length packet passes intact and sets the sticky flag
        chk("err_before_long", err_long_out, 0);
        send_pkt(0, 6, 4'hF, 4'hA, -1, 0);
        wait_drain(200);
        chk("long_err", err_long_out, 1);
        chk("long_beats", pkt_beats_out, 6);
        chk("long_done_count", done_cnt, pkts_sent);

        // Reset asserted mid-packet: outputs clear asynchronously, packet dropped
        rdy_mode = 1;
        send_pkt(1, 8, 4'hF, 4'hF, -1, 0);
        wait_m_valid(50);
        dc0 = done_cnt;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_m", {m_valid_out, m_last_out, m_keep_out, m_data_out, m_src_out}, 0);
        chk("async_reset_misc", {s_ready_out, pkt_done_out, pkt_beats_out, err_long_out}, 0);
        for (int i = 0; i < NSRC; i++) begin
            stim_q[i].delete();
            exp_q[i].delete();
            len_q[i].delete();
        end
        order_q.delete();
        cur_v = '0;
        s_valid_in = '0;
        s_last_in = '0;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_reset_idle", m_valid_out, 0);
        end
        chk("reset_no_done", done_cnt, dc0);

        // Recovery after reset
        send_pkt(0, 2, 4'hF, 4'h6, -1, 0);
        order_q.push_back(0);
        wait_drain(200);
        chk("recover_beats", pkt_beats_out, 2);
        chk("recover_err_clear", err_long_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
